// File: rtl/apb_pkg.sv
// ============================================================================
// Module : apb_pkg
// Brief  : Shared constants and state encoding for the APB register slave.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package apb_pkg;

    localparam logic [1:0] C_IDLE  = 2'd0;
    localparam logic [1:0] C_SETUP = 2'd1;
    localparam logic [1:0] C_WAIT  = 2'd2;
    localparam logic [1:0] C_RESP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = C_IDLE,
        ST_SETUP = C_SETUP,
        ST_WAIT  = C_WAIT,
        ST_RESP  = C_RESP
    } apb_state_t;

    localparam int unsigned REG_CNT     = 6;
    localparam int unsigned REG_ID      = 7;
    localparam int unsigned WINDOW_SIZE = 32;

endpackage

`default_nettype wire

// File: rtl/apb_slave_regfile.sv
// ============================================================================
// Module : apb_slave_regfile
// Brief  : Six RW registers, completed-write counter, read mux, error decode.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter logic [31:0] ID_VALUE  = 32'hA9B0_0001
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic [31:0] dec_addr,
    input  logic        dec_write,
    output logic        dec_err,
    output logic [2:0]  dec_idx,
    input  logic [2:0]  rd_idx,
    output logic [31:0] rd_data,
    input  logic        wr_en,
    input  logic [2:0]  wr_idx,
    input  logic [31:0] wr_data
);

    logic [31:0] r_regs [0:5];
    logic [31:0] r_cnt;
    logic [31:0] w_off;
    logic        w_hit;
    logic        w_ro;

    assign w_off   = dec_addr - BASE_ADDR;
    assign w_hit   = (w_off < 32'(WINDOW_SIZE)) && (dec_addr[1:0] == 2'b00);
    assign dec_idx = w_off[4:2];
    assign w_ro    = (dec_idx == 3'(REG_CNT)) || (dec_idx == 3'(REG_ID));
    assign dec_err = !w_hit || (dec_write && w_ro);

    always_ff @(posedge hclk) begin
        if (hresetn) begin
            for (int i = 0; i < 6; i++) begin
                r_regs[i] <= 32'd0;
            end
            r_cnt <= 32'd0;
        end else if (wr_en) begin
            for (int i = 0; i < 6; i++) begin
                if (wr_idx == 3'(i)) begin
                    r_regs[i] <= wr_data;
                end
            end
            r_cnt <= r_cnt + 32'd1;
        end
    end

    always_comb begin
        rd_data = ID_VALUE;
        for (int i = 0; i < 6; i++) begin
            if (rd_idx == 3'(i)) begin
                rd_data = r_regs[i];
            end
        end
        if (rd_idx == 3'(REG_CNT)) begin
            rd_data = r_cnt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/apb_slave.sv
// ============================================================================
// Module : apb_slave
// Brief  : APB register-file responder with programmable wait states.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module apb_slave
    import apb_pkg::*;
#(
    parameter int          SEL_IDX     = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic [2:0]  psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr
);

    // SETUP already counts as the first access cycle, so the counter starts one lower.
    localparam logic [3:0] C_WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam bit         C_NO_WAIT   = (WAIT_CYCLES == 0);

    apb_state_t  r_state;
    apb_state_t  w_next;
    logic [3:0]  r_wait;
    logic [2:0]  r_idx;
    logic        r_write;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [31:0] r_prdata;
    logic        r_pready;
    logic        r_pslverr;

    logic        w_sel;
    logic        w_access;
    logic        w_accept;
    logic        w_commit;
    logic        w_dec_err;
    logic [2:0]  w_dec_idx;
    logic [31:0] w_rd_data;
    logic        w_unused_psel;

    assign w_sel         = psel[SEL_IDX];
    assign w_access      = w_sel && penable;
    assign w_accept      = (r_state == ST_IDLE) && w_sel && !penable;
    assign w_unused_psel = ^psel;

    apb_slave_regfile #(
        .BASE_ADDR (BASE_ADDR),
        .ID_VALUE  (ID_VALUE)
    ) u_regfile (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .dec_addr  (paddr),
        .dec_write (pwrite),
        .dec_err   (w_dec_err),
        .dec_idx   (w_dec_idx),
        .rd_idx    (r_idx),
        .rd_data   (w_rd_data),
        .wr_en     (w_commit),
        .wr_idx    (r_idx),
        .wr_data   (r_wdata)
    );

    always_comb begin
        w_next   = r_state;
        w_commit = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_sel && !penable) begin
                    w_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (!w_access) begin
                    w_next = ST_IDLE;
                end else if (C_NO_WAIT) begin
                    w_next = ST_RESP;
                end else begin
                    w_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!w_access) begin
                    w_next = ST_IDLE;
                end else if (r_wait == 4'd0) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                w_next   = ST_IDLE;
                w_commit = w_access && r_write && !r_err;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hresetn) begin
            r_state <= ST_IDLE;
            r_wait  <= 4'd0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_SETUP) begin
                r_wait <= C_WAIT_LOAD;
            end else if ((r_state == ST_WAIT) && (r_wait != 4'd0)) begin
                r_wait <= r_wait - 4'd1;
            end
        end
    end

    // Transfer attributes are frozen at the setup phase; later bus changes are ignored.
    always_ff @(posedge hclk) begin
        if (hresetn) begin
            r_idx   <= 3'd0;
            r_write <= 1'b0;
            r_wdata <= 32'd0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_idx   <= w_dec_idx;
            r_write <= pwrite;
            r_wdata <= pwdata;
            r_err   <= w_dec_err;
        end
    end

    always_ff @(posedge hclk) begin
        if (hresetn) begin
            r_prdata  <= 32'd0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
        end else begin
            r_pready  <= (w_next == ST_RESP);
            r_pslverr <= (w_next == ST_RESP) && r_err;
            r_prdata  <= ((w_next == ST_RESP) && !r_err && !r_write) ? w_rd_data : 32'd0;
        end
    end

    assign prdata  = r_prdata;
    assign pready  = r_pready;
    assign pslverr = r_pslverr;

endmodule

`default_nettype wire

// File: tb/tb_apb_slave.sv
// ============================================================================
// Module : tb_apb_slave
// Brief  : Self-checking bench: three slaves (wait 1/0/3) on one APB bus.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_apb_slave;

    localparam logic [31:0] B  = 32'h8000_0000;
    localparam logic [31:0] ID = 32'hA9B0_0001;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    wire  [31:0] prdata [3];
    wire  [2:0]  pready;
    wire  [2:0]  pslverr;

    int tests = 0;
    int fails = 0;
    int wt [3] = '{1, 0, 3};

    logic [31:0] mregs [3][6];
    logic [31:0] mcnt  [3];

    always #5 hclk = ~hclk;

    apb_slave #(.SEL_IDX(0), .BASE_ADDR(B), .WAIT_CYCLES(1), .ID_VALUE(ID)) u_d0 (
        .hclk(hclk), .hresetn(hresetn), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]));
    apb_slave #(.SEL_IDX(1), .BASE_ADDR(B), .WAIT_CYCLES(0), .ID_VALUE(ID)) u_d1 (
        .hclk(hclk), .hresetn(hresetn), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]));
    apb_slave #(.SEL_IDX(2), .BASE_ADDR(B), .WAIT_CYCLES(3), .ID_VALUE(ID)) u_d2 (
        .hclk(hclk), .hresetn(hresetn), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata[2]), .pready(pready[2]), .pslverr(pslverr[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        for (int s = 0; s < 3; s++) begin
            for (int r = 0; r < 6; r++) mregs[s][r] = 32'd0;
            mcnt[s] = 32'd0;
        end
    endtask

    function automatic bit m_err(input logic [31:0] a, input logic w);
        logic [31:0] off;
        int          reg_no;
        off    = a - B;
        reg_no = int'(off / 4);
        if (off >= 32 || (a % 4) != 0) return 1'b1;
        return w && (reg_no >= 6);
    endfunction

    function automatic logic [31:0] m_read(input int s, input logic [31:0] a);
        int reg_no;
        reg_no = int'((a - B) / 4);
        if (reg_no < 6)  return mregs[s][reg_no];
        if (reg_no == 6) return mcnt[s];
        return ID;
    endfunction

    // One full transfer; the bus is scrambled during the access phase.
    task automatic xfer(input int s, input logic [2:0] sel, input logic [31:0] addr,
                        input logic wr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err, output int n);
        @(negedge hclk);
        psel = sel; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wd;
        @(negedge hclk);
        penable = 1'b1; pwdata = ~wd; paddr = addr ^ 32'h0000_0004; n = 1;
        while (!pready[s] && n < 40) begin
            @(negedge hclk);
            n++;
        end
        rd  = prdata[s];
        err = pslverr[s];
    endtask

    task automatic idle();
        @(negedge hclk);
        chk("pready_one_cycle", {29'd0, pready}, 32'd0);
        psel = 3'b000; penable = 1'b0;
    endtask

    task automatic do_op(input string tag, input int s, input logic [2:0] sel,
                         input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                         input bit b2b);
        logic [31:0] rd, exp_rd;
        logic        err, exp_err;
        int          n;
        exp_err = m_err(addr, wr);
        exp_rd  = (wr || exp_err) ? 32'd0 : m_read(s, addr);
        xfer(s, sel, addr, wr, wd, rd, err, n);
        chk({tag, "_cycles"}, 32'(n), 32'(wt[s] + 2));
        chk({tag, "_pslverr"}, {31'd0, err}, {31'd0, exp_err});
        chk({tag, "_prdata"}, rd, exp_rd);
        if (wr && !exp_err) begin
            mregs[s][int'((addr - B) / 4)] = wd;
            mcnt[s] = mcnt[s] + 32'd1;
        end
        if (!b2b) idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        int          n;
        int          any_rdy;

        hresetn = 1'b1; psel = 3'b000; penable = 1'b0; pwrite = 1'b0; paddr = 32'd0; pwdata = 32'd0;
        mreset();
        repeat (3) @(negedge hclk);
        for (int s = 0; s < 3; s++) begin
            chk("reset_prdata", prdata[s], 32'd0);
            chk("reset_pready", {31'd0, pready[s]}, 32'd0);
            chk("reset_pslverr", {31'd0, pslverr[s]}, 32'd0);
        end
        hresetn = 1'b0;

        // Basic write/readback on the one-wait-state slave
        do_op("wr_reg1", 0, 3'b001, B + 32'h4, 1'b1, 32'hDEAD_BEEF, 1'b0);
        xfer(0, 3'b001, B + 32'h4, 1'b0, 32'd0, rd, err, n);
        idle();
        chk("rd_reg1_data", rd, 32'hDEAD_BEEF);
        chk("rd_reg1_cycles", 32'(n), 32'd3);
        chk("rd_reg1_err", {31'd0, err}, 32'd0);
        xfer(0, 3'b001, B + 32'h18, 1'b0, 32'd0, rd, err, n);
        idle();
        chk("rd_cnt_after_write", rd, 32'd1);
        xfer(0, 3'b001, B + 32'h1C, 1'b0, 32'd0, rd, err, n);
        idle();
        chk("rd_id", rd, 32'hA9B0_0001);

        // Error responses
        do_op("wr_cnt_ro", 0, 3'b001, B + 32'h18, 1'b1, 32'h1234_5678, 1'b0);
        do_op("wr_id_ro", 0, 3'b001, B + 32'h1C, 1'b1, 32'h1234_5678, 1'b0);
        do_op("rd_cnt_unchanged", 0, 3'b001, B + 32'h18, 1'b0, 32'd0, 1'b0);
        do_op("wr_miss", 0, 3'b001, B + 32'h20, 1'b1, 32'hFFFF_0000, 1'b0);
        do_op("rd_miss", 0, 3'b001, B + 32'h20, 1'b0, 32'd0, 1'b0);
        do_op("wr_misalign", 0, 3'b001, B + 32'h2, 1'b1, 32'h0F0F_0F0F, 1'b0);
        do_op("rd_misalign", 0, 3'b001, B + 32'h2, 1'b0, 32'd0, 1'b0);
        do_op("rd_below_base", 0, 3'b001, B - 32'h4, 1'b0, 32'd0, 1'b0);
        do_op("rd_reg0_clean", 0, 3'b001, B, 1'b0, 32'd0, 1'b0);
        do_op("rd_reg1_clean", 0, 3'b001, B + 32'h4, 1'b0, 32'd0, 1'b0);

        // Back-to-back writes on the zero-wait slave
        for (int r = 0; r < 6; r++) begin
            do_op("b2b_wr", 1, 3'b010, B + 32'(r * 4), 1'b1, 32'hC0DE_0000 + 32'(r), 1'b1);
        end
        do_op("b2b_rd_cnt", 1, 3'b010, B + 32'h18, 1'b0, 32'd0, 1'b1);
        for (int r = 0; r < 6; r++) begin
            do_op("b2b_rd", 1, 3'b010, B + 32'(r * 4), 1'b0, 32'd0, 1'b1);
        end
        idle();
        chk("b2b_cnt_six", mcnt[1] == 32'd6 ? m_read(1, B + 32'h18) : 32'hX, 32'd6);

        // Unrelated psel bit also asserted: slave 2 starts but aborts once slave 1 finishes
        do_op("multi_sel", 1, 3'b110, B + 32'hC, 1'b1, 32'h5A5A_A5A5, 1'b0);
        do_op("multi_sel_s2_reg3", 2, 3'b100, B + 32'hC, 1'b0, 32'd0, 1'b0);
        do_op("multi_sel_s2_cnt", 2, 3'b100, B + 32'h18, 1'b0, 32'd0, 1'b0);

        // Select dropped during WAIT on the three-wait slave
        @(negedge hclk);
        psel = 3'b100; penable = 1'b0; paddr = B + 32'h8; pwrite = 1'b1; pwdata = 32'hBAD0_BAD0;
        @(negedge hclk);
        penable = 1'b1;
        any_rdy = 0;
        repeat (2) begin
            @(negedge hclk);
            any_rdy += int'(pready[2]);
        end
        psel = 3'b000; penable = 1'b0;
        repeat (8) begin
            @(negedge hclk);
            any_rdy += int'(pready[2]);
        end
        chk("abort_no_pready", 32'(any_rdy), 32'd0);
        do_op("abort_reg2", 2, 3'b100, B + 32'h8, 1'b0, 32'd0, 1'b0);
        do_op("abort_cnt", 2, 3'b100, B + 32'h18, 1'b0, 32'd0, 1'b0);

        // Reset while a read response is on the bus
        @(negedge hclk);
        psel = 3'b010; penable = 1'b0; paddr = B + 32'h18; pwrite = 1'b0;
        @(negedge hclk);
        penable = 1'b1;
        @(negedge hclk);
        chk("pre_reset_pready", {31'd0, pready[1]}, 32'd1);
        chk("pre_reset_prdata", prdata[1], mcnt[1]);
        hresetn = 1'b1;
        @(negedge hclk);
        for (int s = 0; s < 3; s++) begin
            chk("midrst_prdata", prdata[s], 32'd0);
            chk("midrst_pready", {31'd0, pready[s]}, 32'd0);
            chk("midrst_pslverr", {31'd0, pslverr[s]}, 32'd0);
        end
        hresetn = 1'b0; psel = 3'b000; penable = 1'b0;
        mreset();
        do_op("post_rst_reg0", 1, 3'b010, B, 1'b0, 32'd0, 1'b0);
        do_op("post_rst_cnt", 1, 3'b010, B + 32'h18, 1'b0, 32'd0, 1'b0);

        // Counter wrap
        @(negedge hclk);
        force u_d0.u_regfile.r_cnt = 32'hFFFF_FFFF;
        @(negedge hclk);
        release u_d0.u_regfile.r_cnt;
        mcnt[0] = 32'hFFFF_FFFF;
        do_op("wrap_pre", 0, 3'b001, B + 32'h18, 1'b0, 32'd0, 1'b0);
        do_op("wrap_wr", 0, 3'b001, B + 32'h8, 1'b1, 32'h0000_ABCD, 1'b0);
        xfer(0, 3'b001, B + 32'h18, 1'b0, 32'd0, rd, err, n);
        idle();
        chk("wrap_cnt_zero", rd, 32'd0);

        // Randomised traffic against the model
        for (int t = 0; t < 80; t++) begin
            int          s, kind;
            logic [31:0] a;
            s    = int'($urandom_range(0, 2));
            kind = int'($urandom_range(0, 9));
            a    = B + 32'($urandom_range(0, 7) * 4);
            if (kind == 8) a = B + 32'h20 + 32'($urandom_range(0, 15) * 4);
            if (kind == 9) a = a + 32'($urandom_range(1, 3));
            do_op("rand", s, 3'(1 << s), a, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
        end
        idle();
        for (int s = 0; s < 3; s++) begin
            for (int r = 0; r < 8; r++) begin
                do_op("final_dump", s, 3'(1 << s), B + 32'(r * 4), 1'b0, 32'd0, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
